// File: rtl/coproc_cmd_bridge_pkg.sv
// coproc_bridge_pkg: shared types, status-bit offsets and CLR decode for the coprocessor command bridge.
package coproc_bridge_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Status bit positions, counted upward from the top of the captured coprocessor flags
    localparam int unsigned DONE = 0;
    localparam int unsigned BUSY = 1;
    localparam int unsigned FULL = 2;
    localparam int unsigned OVF  = 3;
    localparam int unsigned TMO  = 4;
    localparam int unsigned STATUS_W = 5;

    function automatic logic is_clr(input logic [63:0] word, input int unsigned width);
        return &(word | ~((64'd1 << width) - 64'd1));
    endfunction

endpackage

// File: rtl/coproc_cmd_bridge_fifo.sv
// bridge_fifo: show-ahead synchronous FIFO holding pending coprocessor instructions.
module bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 29
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          wr_en, rd_en;

    assign rd_en   = pop_i && !empty_o;
    // A push at full is only legal when the head leaves in the same cycle
    assign wr_en   = push_i && (!full_o || rd_en);
    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/coproc_cmd_bridge.sv
// coproc_cmd_bridge: HPS PIO to coprocessor bridge with instruction queue, issue handshake and sticky status.
// Define COPROC_CMD_BRIDGE_TIMEOUT_EN to enable the WAIT-state watchdog and the tmo status bit.
module coproc_cmd_bridge
    import coproc_bridge_pkg::*;
#(
    parameter int INSTR_W = 29,
    parameter int DATA_W  = 8,
    parameter int FLAG_W  = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTR_W-1:0]           instruction_in,
    input  logic                         enable_in,
    output logic [INSTR_W-1:0]           cop_instr,
    output logic                         cop_valid,
    input  logic                         cop_ready,
    input  logic                         cop_done,
    input  logic [DATA_W-1:0]            cop_data,
    input  logic [FLAG_W-1:0]            cop_flags,
    output logic [DATA_W-1:0]            dataout,
    output logic [FLAG_W+STATUS_W-1:0]   flags_out
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    state_t               state_q, state_d;
    logic                 enable_q;
    logic [INSTR_W-1:0]   cop_instr_q, cop_instr_d;
    logic                 cop_valid_q, cop_valid_d;
    logic [DATA_W-1:0]    dataout_q;
    logic [FLAG_W-1:0]    cflags_q;
    logic                 done_q, ovf_q, tmo;
    logic                 cmd, clr, push, pop, drop, capture, expire;
    logic                 q_full, q_empty;
    logic [AW:0]          q_count;
    logic [INSTR_W-1:0]   q_head;

    assign cmd     = enable_in && !enable_q;
    assign clr     = cmd && is_clr(64'(instruction_in), INSTR_W);
    assign pop     = state_q == ISSUE && cop_valid_q && cop_ready;
    assign push    = cmd && !clr && (!q_full || pop);
    assign drop    = cmd && !clr && !push;
    assign capture = state_q == WAIT && cop_done;

    bridge_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (instruction_in),
        .dout_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

`ifdef COPROC_CMD_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
    logic          tmo_q;

    assign expire = state_q == WAIT && !cop_done && tcnt_q == TW'(TIMEOUT - 1);
    assign tmo    = tmo_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != WAIT) tcnt_q <= '0;
        else tcnt_q <= tcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= 1'b0;
        else tmo_q <= expire ? 1'b1 : clr ? 1'b0 : tmo_q;
    end
`else
    assign expire = 1'b0;
    assign tmo    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cop_valid_d = cop_valid_q;
        cop_instr_d = cop_instr_q;
        case (state_q)
            IDLE: if (!q_empty) begin
                state_d     = ISSUE;
                cop_valid_d = 1'b1;
                cop_instr_d = q_head;
            end
            ISSUE: if (cop_ready) begin
                state_d     = WAIT;
                cop_valid_d = 1'b0;
            end
            WAIT: if (capture || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            cop_valid_q <= 1'b0;
            cop_instr_q <= '0;
            dataout_q   <= '0;
            cflags_q    <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_in;
            cop_valid_q <= cop_valid_d;
            cop_instr_q <= cop_instr_d;
            dataout_q   <= capture ? cop_data : dataout_q;
            cflags_q    <= capture ? cop_flags : cflags_q;
            // A completing result outranks a clear arriving in the same cycle
            done_q      <= capture ? 1'b1 : (clr || push) ? 1'b0 : done_q;
            ovf_q       <= drop ? 1'b1 : clr ? 1'b0 : ovf_q;
        end
    end

    assign cop_valid = cop_valid_q;
    assign cop_instr = cop_instr_q;
    assign dataout   = dataout_q;
    assign flags_out[FLAG_W-1:0]    = cflags_q;
    assign flags_out[FLAG_W + DONE] = done_q;
    assign flags_out[FLAG_W + BUSY] = state_q != IDLE || q_count != '0;
    assign flags_out[FLAG_W + FULL] = q_full;
    assign flags_out[FLAG_W + OVF]  = ovf_q;
    assign flags_out[FLAG_W + TMO]  = tmo;

endmodule
